// File: rtl/alu_share_arbiter.sv
// Round-robin front end that time-shares one start/done execution unit
// between NREQ requesters, returning each result tagged with its requester id.
module alu_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [2*NREQ-1:0]       req_op,
  input  logic [WIDTH*NREQ-1:0]   req_a,
  input  logic [WIDTH*NREQ-1:0]   req_b,
  output logic                    alu_start,
  output logic [1:0]              alu_op,
  output logic [WIDTH-1:0]        alu_a,
  output logic [WIDTH-1:0]        alu_b,
  input  logic                    alu_done,
  input  logic [WIDTH-1:0]        alu_result,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic [WIDTH-1:0]        rsp_data,
  output logic                    busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_RESP} state_t;

  state_t           r_state, w_state_nxt;
  logic [IDW-1:0]   r_rr_ptr;
  logic [1:0]       r_alu_op;
  logic [WIDTH-1:0] r_alu_a, r_alu_b, r_rsp_data;
  logic [IDW-1:0]   r_rsp_id;

  logic             w_gnt_vld;
  logic [IDW-1:0]   w_gnt_id, w_ptr_nxt;
  logic [NREQ-1:0]  w_sel;
  logic [1:0]       w_gnt_op;
  logic [WIDTH-1:0] w_gnt_a, w_gnt_b;
  logic             w_accept, w_capture;
  int               w_dist, w_best;

  // Winner = valid requester with the smallest forward distance from rr_ptr.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    w_sel     = '0;
    w_gnt_op  = '0;
    w_gnt_a   = '0;
    w_gnt_b   = '0;
    w_best    = NREQ;
    w_dist    = 0;
    for (int i = 0; i < NREQ; i++) begin
      w_dist = (i >= int'(r_rr_ptr)) ? i - int'(r_rr_ptr)
                                     : i + NREQ - int'(r_rr_ptr);
      if (req_valid[i] && (w_dist < w_best)) begin
        w_best    = w_dist;
        w_gnt_vld = 1'b1;
        w_gnt_id  = IDW'(i);
        w_sel     = '0;
        w_sel[i]  = 1'b1;
        w_gnt_op  = req_op[2*i +: 2];
        w_gnt_a   = req_a[WIDTH*i +: WIDTH];
        w_gnt_b   = req_b[WIDTH*i +: WIDTH];
      end
    end
  end

  assign w_ptr_nxt = (w_gnt_id == IDW'(NREQ-1)) ? '0 : w_gnt_id + IDW'(1);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    req_ready   = '0;
    alu_start   = 1'b0;
    rsp_valid   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy      = 1'b0;
        req_ready = w_sel;
        if (w_gnt_vld) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        alu_start   = 1'b1;
        w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        if (alu_done) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operands and id are captured once at accept and held until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr   <= '0;
      r_alu_op   <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_rsp_id   <= '0;
      r_rsp_data <= '0;
    end else begin
      if (w_accept) begin
        r_rr_ptr <= w_ptr_nxt;
        r_alu_op <= w_gnt_op;
        r_alu_a  <= w_gnt_a;
        r_alu_b  <= w_gnt_b;
        r_rsp_id <= w_gnt_id;
      end
      if (w_capture) r_rsp_data <= alu_result;
    end
  end

  assign alu_op   = r_alu_op;
  assign alu_a    = r_alu_a;
  assign alu_b    = r_alu_b;
  assign rsp_id   = r_rsp_id;
  assign rsp_data = r_rsp_data;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized bench for alu_share_arbiter: transaction-level reference model,
// emulated execution unit, and directed scenarios for ordering, backpressure, wrap and reset.
module tb_alu_share_arbiter;
  localparam int NREQ = 4, WIDTH = 8, IDW = 2;

  logic        clk, rst;
  logic [3:0]  req_valid, req_ready;
  logic [7:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        alu_start, alu_done, rsp_valid, rsp_ready, busy;
  logic [1:0]  alu_op, rsp_id;
  logic [7:0]  alu_a, alu_b, alu_result, rsp_data;

  alu_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .alu_start(alu_start),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_done(alu_done),
    .alu_result(alu_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0, checks = 0, cyc = 0;

  // reference model: one outstanding transaction and its progress flags
  int         m_ptr = 0;
  bit         m_have = 0, m_started = 0, m_done = 0;
  logic [1:0] m_op = '0, m_id = '0;
  logic [7:0] m_a = '0, m_b = '0, m_data = '0;

  // stimulus knobs
  bit         k_use_fix = 1, k_hold = 0, k_stray = 0;
  logic [3:0] k_fix_valid = '0;
  int         k_rsp_pct = 100, k_dmin = 1, k_dmax = 1;

  // emulated execution unit
  int         u_cnt = -1;
  logic [7:0] u_res = '0;

  int obs_q[$];
  int acc_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] unit_fn(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a + b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic int winner(input logic [3:0] v, input int p);
    int i;
    for (int k = 0; k < NREQ; k++) begin
      i = (p + k) % NREQ;
      if (((v >> i) & 4'd1) != 4'd0) return i;
    end
    return -1;
  endfunction

  task automatic gen();
    req_valid = k_use_fix ? k_fix_valid : 4'($urandom_range(0, 15));
    if (!k_hold) begin
      req_op = 8'($urandom);
      req_a  = $urandom;
      req_b  = $urandom;
    end
    rsp_ready  = ($urandom_range(0, 99) < k_rsp_pct);
    alu_done   = 1'b0;
    alu_result = 8'($urandom);
    if (u_cnt > 0) begin
      u_cnt--;
      if (u_cnt == 0) begin
        alu_done   = 1'b1;
        alu_result = u_res;
        u_cnt      = -1;
      end
    end else if (k_stray && !(m_have && m_started && !m_done) && $urandom_range(0, 3) == 0)
      alu_done = 1'b1;
  endtask

  task automatic check();
    int w;
    logic [3:0] exp_rdy;
    exp_rdy = '0;
    if (!m_have) begin
      w = winner(req_valid, m_ptr);
      if (w >= 0) exp_rdy = 4'(1 << w);
    end
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("alu_start", 32'(alu_start), 32'(m_have && !m_started));
    chk("busy",      32'(busy),      32'(m_have));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_done));
    chk("alu_op",    32'(alu_op),    32'(m_op));
    chk("alu_a",     32'(alu_a),     32'(m_a));
    chk("alu_b",     32'(alu_b),     32'(m_b));
    chk("rsp_id",    32'(rsp_id),    32'(m_id));
    chk("rsp_data",  32'(rsp_data),  32'(m_data));
    for (int i = 0; i < NREQ; i++)
      if (((req_ready >> i) & 4'd1) != 4'd0) begin
        obs_q.push_back(i);
        acc_q.push_back(cyc);
      end
    if (m_have && !m_started && !rst) begin
      u_cnt = $urandom_range(k_dmin, k_dmax);
      u_res = unit_fn(m_op, m_a, m_b);
    end
  endtask

  task automatic update();
    int w;
    if (rst) begin
      m_have = 0; m_started = 0; m_done = 0; m_ptr = 0;
      m_op = '0; m_id = '0; m_a = '0; m_b = '0; m_data = '0;
    end else if (!m_have) begin
      w = winner(req_valid, m_ptr);
      if (w >= 0) begin
        m_have = 1; m_started = 0; m_done = 0;
        m_id  = 2'(w);
        m_op  = 2'(req_op >> (2*w));
        m_a   = 8'(req_a >> (8*w));
        m_b   = 8'(req_b >> (8*w));
        m_ptr = (w + 1) % NREQ;
      end
    end else if (!m_started) m_started = 1;
    else if (!m_done) begin
      if (alu_done) begin
        m_done = 1;
        m_data = alu_result;
      end
    end else if (rsp_ready) begin
      m_have = 0;
      m_done = 0;
    end
    cyc++;
  endtask

  task automatic tick();
    #1;
    check();
    update();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      gen();
      tick();
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    u_cnt = -1;
    gen();
    tick();
    rst = 1'b0;
    obs_q.delete();
    acc_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;
    rst = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
    alu_done = 1'b0; alu_result = '0; rsp_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // single request from port 1, unit answers 3 cycles after start
    k_use_fix = 1; k_fix_valid = 4'b0010; k_hold = 1; k_stray = 1;
    req_op = 8'b0000_1000; req_a = 32'h0000_1200; req_b = 32'h0000_3400;
    k_dmin = 3; k_dmax = 3; k_rsp_pct = 100;
    run(3);
    k_fix_valid = 4'b0000;
    run(8);
    chk("t1_grant", 32'(obs_q.size() > 0 ? obs_q[0] : -1), 32'd1);
    k_hold = 0;

    // all requesters busy: strict rotation, 4-cycle spacing
    do_reset();
    k_fix_valid = 4'b1111; k_stray = 0; k_dmin = 1; k_dmax = 1;
    run(22);
    chk("t2_ngrants", 32'(obs_q.size() >= 5), 32'd1);
    if (obs_q.size() >= 5)
      for (int k = 0; k < 5; k++) begin
        chk("t2_order", 32'(obs_q[k]), 32'(k % NREQ));
        if (k > 0) chk("t2_spacing", 32'(acc_q[k] - acc_q[k-1]), 32'd4);
      end

    // backpressure held in RESP, then released
    k_rsp_pct = 0;
    run(14);
    k_rsp_pct = 100;
    run(6);

    // wrap: take req 2 first so rr_ptr lands on 3, then offer 0 and 2
    do_reset();
    k_fix_valid = 4'b0100;
    found = 0;
    for (int n = 0; n < 10 && !found; n++) begin
      gen();
      tick();
      found = (obs_q.size() > 0);
    end
    k_fix_valid = 4'b0101;
    run(16);
    chk("t4_ngrants", 32'(obs_q.size() >= 3), 32'd1);
    if (obs_q.size() >= 3) begin
      chk("t4_first",  32'(obs_q[0]), 32'd2);
      chk("t4_wrap",   32'(obs_q[1]), 32'd0);
      chk("t4_next",   32'(obs_q[2]), 32'd2);
    end

    // reset while BUSY, late done right after, then rotation restarts at 0
    do_reset();
    k_fix_valid = 4'b0001; k_dmin = 4; k_dmax = 4; k_stray = 1;
    found = 0;
    for (int n = 0; n < 10 && !found; n++) begin
      gen();
      if (m_have && m_started && !m_done) begin
        found = 1;
        rst   = 1'b1;
        req_valid = '0;
      end
      tick();
    end
    chk("t5_reach_busy", 32'(found), 32'd1);
    rst = 1'b0;
    k_fix_valid = 4'b0000;
    u_cnt = 1;
    run(6);
    obs_q.delete();
    k_fix_valid = 4'b1111; k_stray = 0; k_dmin = 1; k_dmax = 2;
    run(6);
    chk("t5_ptr_restart", 32'(obs_q.size() > 0 ? obs_q[0] : -1), 32'd0);

    // randomized traffic with stray done pulses and random backpressure
    do_reset();
    k_use_fix = 0; k_rsp_pct = 70; k_dmin = 1; k_dmax = 4; k_stray = 1;
    run(3000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
